ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/integration_pkg.sv | 13 +
 rtl/ahb_arbiter_if.sv | 25 ++
 rtl/rr_priority_picker.sv | 40 ++++
 rtl/ahb_arbiter.sv | 100 ++++++++++
 tb/tb_ahb_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/integration_pkg.sv
// rtl/integration_pkg.sv - shared limits and FSM state type for the AHB arbiter
package integration_pkg;

  localparam int NUM_MASTERS_MAX = 16;
  localparam int HMASTER_W       = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_LOCKED  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - request/grant bundle between bus masters and the arbiter
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
) ();
  import integration_pkg::*;

  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [HMASTER_W-1:0]   hmaster;
  logic                   hmastlock;
  arb_state_e             arb_state;

  modport master (
    output hbusreq, hlock, hready,
    input  hgrant, hmaster, hmastlock, arb_state
  );

  modport slave (
    input  hbusreq, hlock, hready,
    output hgrant, hmaster, hmastlock, arb_state
  );

endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - first set request at or after start_i, wrapping at N-1
module rr_priority_picker
  import integration_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [HMASTER_W-1:0] start_i,
  output logic                 valid_o,
  output logic [HMASTER_W-1:0] index_o
);

  localparam int SW = HMASTER_W + 1;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [SW-1:0]  offset;
  logic [SW-1:0]  sum;

  // Doubling the vector lets a plain shift implement the wrap-around rotation.
  assign req_dbl = {req_i, req_i};
  assign req_rot = N'(req_dbl >> start_i);

  always_comb begin
    valid_o = 1'b0;
    offset  = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        valid_o = 1'b1;
        offset  = SW'(j);
      end
    end
    sum = {1'b0, start_i} + offset;
    if (sum >= SW'(N)) begin
      sum = sum - SW'(N);
    end
    index_o = sum[HMASTER_W-1:0];
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB bus arbiter with locked-transfer support
module ahb_arbiter
  import integration_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic         hclk,
  input  logic         hreset,
  ahb_arbiter_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [HMASTER_W-1:0]   hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  logic                   has_grant;
  logic                   owner_req;
  logic                   owner_lock;
  logic [HMASTER_W-1:0]   owner_idx;
  logic [HMASTER_W-1:0]   base_idx;
  logic [HMASTER_W-1:0]   start_idx;
  logic                   pick_valid;
  logic [HMASTER_W-1:0]   pick_idx;

  // The rotation pivots on the master whose grant is in effect, so a full
  // request set advances one master per arbitration; hmaster is only the
  // fallback before the first grant after reset.
  always_comb begin
    has_grant  = |hgrant_q;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    owner_idx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) begin
        owner_idx  = HMASTER_W'(i);
        owner_req  = bus.hbusreq[i];
        owner_lock = bus.hlock[i];
      end
    end
    base_idx  = has_grant ? owner_idx : hmaster_q;
    start_idx = (base_idx == HMASTER_W'(NUM_MASTERS - 1)) ? '0
                                                          : base_idx + HMASTER_W'(1);
  end

  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req_i   (bus.hbusreq),
    .start_i (start_idx),
    .valid_o (pick_valid),
    .index_o (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    hgrant_d    = hgrant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (bus.hready) begin
      if (has_grant) begin
        hmaster_d   = owner_idx;
        hmastlock_d = owner_lock;
      end
      if (owner_req && owner_lock) begin
        state_d = ARB_LOCKED;
      end else if (pick_valid) begin
        state_d = ARB_GRANTED;
        for (int i = 0; i < NUM_MASTERS; i++) begin
          hgrant_d[i] = (pick_idx == HMASTER_W'(i));
        end
      end else begin
        state_d                  = ARB_IDLE;
        hgrant_d                 = '0;
        hgrant_d[DEFAULT_MASTER] = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ARB_IDLE;
      hgrant_q    <= '0;
      hmaster_q   <= HMASTER_W'(DEFAULT_MASTER);
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;
  assign bus.arb_state = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed and randomized checks of ahb_arbiter against a reference model
module tb_ahb_arbiter;
  import integration_pkg::*;

  localparam int N   = 4;
  localparam int DEF = 0;

  logic hclk   = 1'b0;
  logic hreset = 1'b1;

  ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS    (N),
    .DEFAULT_MASTER (DEF)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;

  // Reference model: grant owner (-1 = none), address-phase owner, lock flag, state.
  int         m_grant;
  int         m_master;
  int         m_lock;
  arb_state_e m_state;

  int         rose_idx;
  logic [N-1:0] prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] model_grant_vec();
    logic [N-1:0] v;
    v = '0;
    if (m_grant >= 0) v[m_grant] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_grant    = -1;
    m_master   = DEF;
    m_lock     = 0;
    m_state    = ARB_IDLE;
    rose_idx   = -1;
    prev_grant = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] req, input logic [N-1:0] lock, input logic rdy);
    int base;
    int pick;
    if (rdy !== 1'b1) return;
    if (m_grant >= 0) begin
      m_master = m_grant;
      m_lock   = lock[m_grant] ? 1 : 0;
      if (req[m_grant] && lock[m_grant]) begin
        m_state = ARB_LOCKED;
        return;
      end
    end
    if (req == '0) begin
      m_grant = DEF;
      m_state = ARB_IDLE;
      return;
    end
    base = (m_grant >= 0) ? m_grant : m_master;
    pick = -1;
    for (int k = 1; k <= N && pick < 0; k++) begin
      if (req[(base + k) % N]) pick = (base + k) % N;
    end
    m_grant = pick;
    m_state = ARB_GRANTED;
  endtask

  task automatic sample_check(input string tag);
    logic [N-1:0] g;
    g = bus.hgrant;
    chk({tag, ":hgrant"},    32'(g),             32'(model_grant_vec()));
    chk({tag, ":hmaster"},   32'(bus.hmaster),   32'(m_master));
    chk({tag, ":hmastlock"}, 32'(bus.hmastlock), 32'(m_lock));
    chk({tag, ":state"},     32'(bus.arb_state), 32'(m_state));
    chk({tag, ":onehot0"},   32'($onehot0(g)),   32'(1));
  endtask

  task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lock, input logic rdy);
    int pend;
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.hready  = rdy;
    pend = rose_idx;
    @(posedge hclk);
    model_edge(req, lock, rdy);
    @(negedge hclk);
    sample_check("cyc");
    if (pend >= 0 && rdy) chk("rose_hmaster", 32'(bus.hmaster), 32'(pend));
    rose_idx = -1;
    for (int i = 0; i < N; i++) begin
      if (bus.hgrant[i] && !prev_grant[i]) rose_idx = i;
    end
    prev_grant = bus.hgrant;
  endtask

  // Asserts reset between edges so the asynchronous clear is observed directly.
  task automatic apply_reset();
    #2 hreset = 1'b1;
    #1;
    model_reset();
    sample_check("reset");
    chk("reset_hgrant",    32'(bus.hgrant),    32'(0));
    chk("reset_hmaster",   32'(bus.hmaster),   32'(DEF));
    chk("reset_hmastlock", 32'(bus.hmastlock), 32'(0));
    @(negedge hclk);
    hreset = 1'b0;
  endtask

  int rr_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.hready  = 1'b1;
    model_reset();
    @(negedge hclk);
    @(negedge hclk);
    sample_check("por");
    chk("por_hgrant", 32'(bus.hgrant), 32'(0));
    hreset = 1'b0;

    // Park on the default master after reset release.
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("park_hgrant",    32'(bus.hgrant),    32'(4'b0001));
    chk("park_hmaster",   32'(bus.hmaster),   32'(0));
    chk("park_hmastlock", 32'(bus.hmastlock), 32'(0));

    // Full request set rotates one master per arbitration.
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 4'b0000, 1'b1);
      chk("rr_seq", 32'(bus.hgrant), 32'(1) << rr_seq[k]);
    end

    // Lock on master 2 with everyone else requesting.
    cycle(4'b1111, 4'b0100, 1'b1);
    chk("lock_grant", 32'(bus.hgrant), 32'(4'b0100));
    cycle(4'b1111, 4'b0100, 1'b1);
    chk("lock_hold0",     32'(bus.hgrant),    32'(4'b0100));
    chk("lock_hmastlock", 32'(bus.hmastlock), 32'(1));
    chk("lock_hmaster",   32'(bus.hmaster),   32'(2));
    for (int k = 0; k < 2; k++) begin
      cycle(4'b1111, 4'b0100, 1'b1);
      chk("lock_hold", 32'(bus.hgrant),    32'(4'b0100));
      chk("lock_state", 32'(bus.arb_state), 32'(ARB_LOCKED));
    end
    cycle(4'b1111, 4'b0000, 1'b1);
    chk("unlock_next", 32'(bus.hgrant), 32'(4'b1000));

    // Stall: request changes while hready is low must not move anything.
    cycle(4'b0101, 4'b0000, 1'b0);
    chk("stall_hgrant0", 32'(bus.hgrant), 32'(4'b1000));
    cycle(4'b0010, 4'b0000, 1'b0);
    chk("stall_hgrant1", 32'(bus.hgrant), 32'(4'b1000));
    cycle(4'b0001, 4'b0000, 1'b0);
    chk("stall_hgrant2",  32'(bus.hgrant),  32'(4'b1000));
    chk("stall_hmaster",  32'(bus.hmaster), 32'(2));
    cycle(4'b0010, 4'b0000, 1'b1);
    chk("stall_release",  32'(bus.hgrant),  32'(4'b0010));
    chk("stall_hmaster1", 32'(bus.hmaster), 32'(3));

    // Reset while master 1 holds a lock.
    cycle(4'b0010, 4'b0010, 1'b1);
    chk("lock1_state",     32'(bus.arb_state), 32'(ARB_LOCKED));
    chk("lock1_hmastlock", 32'(bus.hmastlock), 32'(1));
    apply_reset();
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("post_rst_park", 32'(bus.hgrant), 32'(4'b0001));
    cycle(4'b0000, 4'b0000, 1'b1);
    chk("post_rst_hmaster", 32'(bus.hmaster),   32'(0));
    chk("post_rst_state",   32'(bus.arb_state), 32'(ARB_IDLE));

    // Randomized traffic against the model, with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] req;
      logic [N-1:0] lock;
      logic         rdy;
      req  = N'($urandom);
      lock = N'($urandom) & N'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      if (n == 200) apply_reset();
      cycle(req, lock, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
